// File: rtl/grf_if.sv
// W-stage write request and D-stage read ports of the general register file.
// The master side is the pipeline and the slave side is the register file.
interface grf_if;
  logic [4:0]  W_A3;
  logic [31:0] W_Reg_Data;
  logic        W_Reg_Write;
  logic [31:0] W_PC;
  logic [4:0]  D_A1;
  logic [4:0]  D_A2;
  logic [31:0] D_RD1;
  logic [31:0] D_RD2;
  logic [31:0] GRF_Write_Cnt;

  modport master (
    output W_A3,
    output W_Reg_Data,
    output W_Reg_Write,
    output W_PC,
    output D_A1,
    output D_A2,
    input  D_RD1,
    input  D_RD2,
    input  GRF_Write_Cnt
  );

  modport slave (
    input  W_A3,
    input  W_Reg_Data,
    input  W_Reg_Write,
    input  W_PC,
    input  D_A1,
    input  D_A2,
    output D_RD1,
    output D_RD2,
    output GRF_Write_Cnt
  );
endinterface

// File: rtl/grf.sv
// 32x32 MIPS register file with same-cycle W-to-D bypass and a retired-write counter.
// Define GRF_TRACE_EN to print one trace line per committed write.
module grf (
  input  logic  clk,
  input  logic  reset,
  grf_if.slave  bus
);

  // $0 is never stored; it reads as constant zero.
  logic [31:0] regs_q [31:1];
  logic [31:0] regs_d [31:1];
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        wr_en;
  logic [31:0] rd1;
  logic [31:0] rd2;

  assign wr_en = bus.W_Reg_Write && (bus.W_A3 != 5'd0);

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (wr_en) begin
      regs_d[bus.W_A3] = bus.W_Reg_Data;
      cnt_d            = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  // Bypass ignores reset so a retiring write is always visible to the D stage.
  always_comb begin
    rd1 = '0;
    if (bus.D_A1 != 5'd0) begin
      if (bus.W_Reg_Write && (bus.W_A3 == bus.D_A1)) begin
        rd1 = bus.W_Reg_Data;
      end else begin
        rd1 = regs_q[bus.D_A1];
      end
    end
  end

  always_comb begin
    rd2 = '0;
    if (bus.D_A2 != 5'd0) begin
      if (bus.W_Reg_Write && (bus.W_A3 == bus.D_A2)) begin
        rd2 = bus.W_Reg_Data;
      end else begin
        rd2 = regs_q[bus.D_A2];
      end
    end
  end

  assign bus.D_RD1         = rd1;
  assign bus.D_RD2         = rd2;
  assign bus.GRF_Write_Cnt = cnt_q;

  // W_PC feeds only the optional trace.
  logic unused_pc;
  assign unused_pc = ^bus.W_PC;

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      $display("%d@%h: $%d <= %h", $time, bus.W_PC, bus.W_A3, bus.W_Reg_Data);
    end
  end
`else
`endif

endmodule

// File: tb/tb_grf.sv
// Self-checking bench for grf: directed cases plus randomized traffic against an array model.
module tb_grf;
  logic clk;
  logic reset;
  grf_if u_if ();

  grf u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  logic [31:0] mem [32];
  logic [31:0] cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (u_if.W_Reg_Write && u_if.W_A3 == a) return u_if.W_Reg_Data;
    return mem[a];
  endfunction

  // One clock: drive at negedge, check reads before the edge, update model, check counter.
  task automatic step(input logic rst, input logic we, input logic [4:0] a3,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                      input bit chk, input string tag);
    @(negedge clk);
    reset = rst;
    u_if.W_Reg_Write = we;
    u_if.W_A3 = a3;
    u_if.W_Reg_Data = wd;
    u_if.W_PC = 32'h0040_3000 + {25'd0, a3, 2'b00};
    u_if.D_A1 = a1;
    u_if.D_A2 = a2;
    #1;
    if (chk) begin
      check({tag, "_rd1"}, u_if.D_RD1, ref_rd(a1));
      check({tag, "_rd2"}, u_if.D_RD2, ref_rd(a2));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      cnt = 32'd0;
    end else if (we && a3 != 5'd0) begin
      mem[a3] = wd;
      cnt = cnt + 32'd1;
    end
    #1;
    if (chk) check({tag, "_cnt"}, u_if.GRF_Write_Cnt, cnt);
  endtask

  // Combinational read with no write active and no clock edge.
  task automatic peek(input logic [4:0] a1, input logic [4:0] a2, input string tag);
    u_if.W_Reg_Write = 1'b0;
    u_if.D_A1 = a1;
    u_if.D_A2 = a2;
    #1;
    check({tag, "_rd1"}, u_if.D_RD1, ref_rd(a1));
    check({tag, "_rd2"}, u_if.D_RD2, ref_rd(a2));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cnt = 32'd0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    reset = 1'b1;
    u_if.W_Reg_Write = 1'b0;
    u_if.W_A3 = '0;
    u_if.W_Reg_Data = '0;
    u_if.W_PC = '0;
    u_if.D_A1 = '0;
    u_if.D_A2 = '0;

    // Initial reset: state undefined before it, so no checks.
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, "init");
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, "init");
    check("reset_cnt", u_if.GRF_Write_Cnt, 32'd0);

    // Random writes, then a two-cycle reset clears everything.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom), 5'($urandom), 1'b1,
           "pre");
    end
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b1, "rst1");
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b1, "rst2");
    for (int a = 0; a < 32; a += 2) peek(5'(a), 5'(a + 1), "rst_zero");
    check("rst_cnt_zero", u_if.GRF_Write_Cnt, 32'd0);

    // Basic write then read.
    step(1'b0, 1'b1, 5'd5, 32'h1234_5678, 5'd0, 5'd0, 1'b1, "wr5");
    peek(5'd5, 5'd4, "rd5");
    check("rd5_val", u_if.D_RD1, 32'h1234_5678);
    check("rd5_cnt", u_if.GRF_Write_Cnt, 32'd1);

    // $0 write is ignored and reads 0 even with a matching W request.
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, "wr0");
    check("wr0_rd", u_if.D_RD1, 32'd0);
    check("wr0_cnt", u_if.GRF_Write_Cnt, 32'd1);

    // Bypass on both ports, then disabled write returns stored value.
    step(1'b0, 1'b1, 5'd7, 32'h1111_2222, 5'd0, 5'd0, 1'b1, "wr7");
    step(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7, 1'b1, "byp7");
    step(1'b0, 1'b0, 5'd7, 32'h5555_5555, 5'd7, 5'd7, 1'b1, "nobyp7");
    check("nobyp7_val", u_if.D_RD2, 32'hDEAD_BEEF);

    // Reset beats a simultaneous write; bypass still visible during it.
    step(1'b0, 1'b1, 5'd3, 32'h0000_1234, 5'd0, 5'd0, 1'b1, "wr3");
    step(1'b1, 1'b1, 5'd3, 32'h0000_AAAA, 5'd3, 5'd3, 1'b1, "rstwr3");
    peek(5'd3, 5'd5, "after_rstwr3");
    check("after_rstwr3_val", u_if.D_RD1, 32'd0);

    // Randomized traffic over a narrow address range to exercise bypass and $0.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
           $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'b1, "rnd");
    end

    // Trace-visible sequence: $1<-1, $0 write, $2<-2.
    step(1'b0, 1'b1, 5'd1, 32'd1, 5'd1, 5'd2, 1'b1, "tr1");
    step(1'b0, 1'b1, 5'd0, 32'd9, 5'd1, 5'd2, 1'b1, "tr0");
    step(1'b0, 1'b1, 5'd2, 32'd2, 5'd1, 5'd2, 1'b1, "tr2");
    peek(5'd1, 5'd2, "tr_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
